// File: rtl/s_machine_pkg.sv
// S-Machine shared types and constants.
// Used by the fetch stage and its PC counter.
package s_machine_pkg;

    localparam int ADDR_W = 8;
    localparam int INST_W = 16;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    localparam logic [3:0] HALT_OPC = 4'b1000;

    typedef enum logic {
        FETCH,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_counter.sv
// Program counter register for the fetch stage.
// Redirect target load beats increment; otherwise hold. Wraps modulo 2^ADDR_W.
module fetch_pc_counter
    import s_machine_pkg::*;
#(
    parameter int               PC_W  = s_machine_pkg::ADDR_W,
    parameter logic [PC_W-1:0]  PC_RST = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_target,
    input  logic [PC_W-1:0] target,
    input  logic            incr,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= PC_RST;
        end else begin
            unique case (1'b1)
                load_target: pc <= target;
                incr:        pc <= pc + 1'b1;
                default:     pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// S-Machine fetch stage: PC, IR and valid/ready handoff to the decoder.
// Optional accept counter enabled by defining INST_FETCH_COUNT_EN.
module inst_fetch_unit
    import s_machine_pkg::*;
#(
    parameter int                ADDR_W      = s_machine_pkg::ADDR_W,
    parameter int                INST_W      = s_machine_pkg::INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [3:0]        HALT_OPCODE = s_machine_pkg::HALT_OPC
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INST_W-1:0] mem_data,
    output logic [INST_W-1:0] ir_data,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
`ifdef INST_FETCH_COUNT_EN
    output logic [15:0]       fetch_count,
`endif
    output logic              halted
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              load;
    logic              accept;
    logic              is_halt;

    assign load = (state == FETCH) && (!ir_valid || ir_ready)
                  && !redirect_valid;
    assign accept  = ir_valid && ir_ready;
    assign is_halt = (mem_data[OPC_MSB:OPC_LSB] == HALT_OPCODE);

    fetch_pc_counter #(
        .PC_W   (ADDR_W),
        .PC_RST (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst         (rst),
        .load_target (redirect_valid),
        .target      (redirect_pc),
        .incr        (load),
        .pc          (pc)
    );

    assign mem_addr = pc;

    // Redirect flushes the IR and clears any halt before load is considered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            halted   <= 1'b0;
            ir_data  <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else if (redirect_valid) begin
            state    <= FETCH;
            halted   <= 1'b0;
            ir_valid <= 1'b0;
        end else if (load) begin
            ir_data  <= mem_data;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            if (is_halt) begin
                state  <= HALTED;
                halted <= 1'b1;
            end
        end else if (accept) begin
            ir_valid <= 1'b0;
        end
    end

`ifdef INST_FETCH_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (accept && fetch_count != 16'hFFFF) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit.
// Memory is modelled as a combinational array indexed by mem_addr.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data;
    logic [15:0] ir_data;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        halted;
`ifdef INST_FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    logic [15:0] mem [256];
    int          n_chk;
    int          n_err;

    assign mem_data = mem[mem_addr];

    inst_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .ir_data        (ir_data),
        .ir_pc          (ir_pc),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef INST_FETCH_COUNT_EN
        .fetch_count    (fetch_count),
`endif
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [7:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
        mem[0] = 16'h0401;
        mem[1] = 16'h0C01;
        mem[2] = 16'h4000;
        mem[3] = 16'h5000;
        mem[7] = 16'h8000;

        rst            = 1'b1;
        ir_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        step();
        step();
        chk("rst_valid", 32'(ir_valid), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'h00);
        chk("rst_data", 32'(ir_data), 32'h0);
        chk("rst_irpc", 32'(ir_pc), 32'h0);
        chk("rst_halt", 32'(halted), 32'd0);

        // Release reset; first IR valid one edge later
        rst      = 1'b0;
        ir_ready = 1'b1;
        chk("pre_valid", 32'(ir_valid), 32'd0);
        step();
        chk("w0_valid", 32'(ir_valid), 32'd1);
        chk("w0_data", 32'(ir_data), 32'h0401);
        chk("w0_pc", 32'(ir_pc), 32'h0);
        step();
        chk("w1_data", 32'(ir_data), 32'h0C01);
        chk("w1_pc", 32'(ir_pc), 32'h1);
        step();
        chk("w2_data", 32'(ir_data), 32'h4000);
        chk("w2_pc", 32'(ir_pc), 32'h2);

        // Backpressure
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_valid", 32'(ir_valid), 32'd1);
            chk("bp_data", 32'(ir_data), 32'h4000);
            chk("bp_pc", 32'(ir_pc), 32'h2);
            chk("bp_addr", 32'(mem_addr), 32'h3);
        end
        ir_ready = 1'b1;
        step();
        chk("w3_data", 32'(ir_data), 32'h5000);
        chk("w3_pc", 32'(ir_pc), 32'h3);
        step();
        chk("w4_pc", 32'(ir_pc), 32'h4);
        chk("w4_data", 32'(ir_data), 32'h1004);

        // Redirect under backpressure
        ir_ready = 1'b0;
        step();
        chk("hold4_pc", 32'(ir_pc), 32'h4);
        redirect(8'h40);
        chk("rd_valid", 32'(ir_valid), 32'd0);
        chk("rd_addr", 32'(mem_addr), 32'h40);
        step();
        chk("rd_irvalid", 32'(ir_valid), 32'd1);
        chk("rd_irpc", 32'(ir_pc), 32'h40);
        chk("rd_irdata", 32'(ir_data), 32'h1040);
        ir_ready = 1'b1;

        // HALT at address 7
        redirect(8'h05);
        step();
        chk("h5_pc", 32'(ir_pc), 32'h5);
        step();
        chk("h6_pc", 32'(ir_pc), 32'h6);
        chk("h6_halt", 32'(halted), 32'd0);
        step();
        chk("h7_pc", 32'(ir_pc), 32'h7);
        chk("h7_data", 32'(ir_data), 32'h8000);
        chk("h7_valid", 32'(ir_valid), 32'd1);
        chk("h7_halt", 32'(halted), 32'd1);
        chk("h7_addr", 32'(mem_addr), 32'h8);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hlt_valid", 32'(ir_valid), 32'd0);
            chk("hlt_addr", 32'(mem_addr), 32'h8);
            chk("hlt_halt", 32'(halted), 32'd1);
        end
        redirect(8'h00);
        chk("res_halt", 32'(halted), 32'd0);
        chk("res_addr", 32'(mem_addr), 32'h0);
        step();
        chk("res_pc", 32'(ir_pc), 32'h0);
        chk("res_data", 32'(ir_data), 32'h0401);
        chk("res_valid", 32'(ir_valid), 32'd1);

        // Wrap FE, FF, 00, 01
        redirect(8'hFE);
        step();
        chk("wr_fe", 32'(ir_pc), 32'hFE);
        step();
        chk("wr_ff", 32'(ir_pc), 32'hFF);
        step();
        chk("wr_00", 32'(ir_pc), 32'h00);
        step();
        chk("wr_01", 32'(ir_pc), 32'h01);

        // Redirect beats a HALT word on mem_data
        redirect(8'h07);
        chk("rh_addr", 32'(mem_addr), 32'h7);
        redirect(8'h20);
        chk("rh_halt", 32'(halted), 32'd0);
        chk("rh_valid", 32'(ir_valid), 32'd0);
        chk("rh_addr2", 32'(mem_addr), 32'h20);
        step();
        chk("rh_irpc", 32'(ir_pc), 32'h20);
        chk("rh_valid2", 32'(ir_valid), 32'd1);

        // Asynchronous reset mid-stream
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(ir_valid), 32'd0);
        chk("ar_addr", 32'(mem_addr), 32'h0);
        chk("ar_irpc", 32'(ir_pc), 32'h0);
        chk("ar_data", 32'(ir_data), 32'h0);
        chk("ar_halt", 32'(halted), 32'd0);
        step();
        rst = 1'b0;

`ifdef INST_FETCH_COUNT_EN
        chk("cnt_rst", 32'(fetch_count), 32'd0);
        ir_ready = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        ir_ready = 1'b0;
        chk("cnt_irpc", 32'(ir_pc), 32'h5);
        redirect(8'h10);
        step();
        chk("cnt_five", 32'(fetch_count), 32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
